// File: rtl/ysyx_22041211_lsu.sv
// Load/store unit between the EX-stage ALU and writeback.
// Takes one instruction at a time and issues one word-aligned memory request.
// It aligns and extends load data, then returns one registered result.
// Optional build macro YSYX_22041211_LSU_MISALIGN_CHECK_EN: misaligned H/W
// accesses fault immediately instead of being truncated to the aligned word.
module ysyx_22041211_lsu #(
  parameter int unsigned DATA_LEN = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DATA_LEN-1:0]   alu_result_i,
  input  logic [DATA_LEN-1:0]   store_data_i,
  input  logic                  mem_ren_i,
  input  logic                  mem_wen_i,
  input  logic [2:0]            funct3_i,
  input  logic [4:0]            rd_i,
  input  logic                  reg_wen_i,
  output logic                  mem_req_valid_o,
  input  logic                  mem_req_ready_i,
  output logic                  mem_req_wen_o,
  output logic [DATA_LEN-1:0]   mem_addr_o,
  output logic [DATA_LEN-1:0]   mem_wdata_o,
  output logic [DATA_LEN/8-1:0] mem_wstrb_o,
  input  logic                  mem_rsp_valid_i,
  input  logic [DATA_LEN-1:0]   mem_rdata_i,
  input  logic                  mem_rsp_err_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_LEN-1:0]   out_data_o,
  output logic [4:0]            out_rd_o,
  output logic                  out_reg_wen_o,
  output logic                  out_err_o
);

  localparam int unsigned STRB_W = DATA_LEN / 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [DATA_LEN-1:0] addr_q, addr_d;
  logic                store_q, store_d;
  logic [2:0]          funct3_q, funct3_d;
  logic [4:0]          rd_q, rd_d;
  logic                reg_wen_q, reg_wen_d;
  logic [DATA_LEN-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]   wstrb_q, wstrb_d;
  logic [DATA_LEN-1:0] out_data_q, out_data_d;
  logic                out_err_q, out_err_d;
  logic                out_reg_wen_q, out_reg_wen_d;

  logic                mem_op_c;
  logic                misalign_c;
  logic [DATA_LEN-1:0] st_wdata_c;
  logic [STRB_W-1:0]   st_wstrb_c;
  logic [7:0]          ld_byte_c;
  logic [15:0]         ld_half_c;
  logic [DATA_LEN-1:0] ld_data_c;

  assign mem_op_c = mem_ren_i | mem_wen_i;

  // Misalignment detection on the incoming instruction (feature build only)
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
  always_comb begin
    misalign_c = 1'b0;
    if (funct3_i[1:0] == 2'b01) misalign_c = alu_result_i[0];
    else if (funct3_i[1:0] == 2'b10) misalign_c = (alu_result_i[1:0] != 2'b00);
  end
`else
  assign misalign_c = 1'b0;
`endif

  // Store lane replication and byte strobes from the incoming address
  always_comb begin
    st_wdata_c = store_data_i;
    st_wstrb_c = 4'b1111;
    case (funct3_i[1:0])
      2'b00: begin
        st_wdata_c = {4{store_data_i[7:0]}};
        st_wstrb_c = 4'b0001 << alu_result_i[1:0];
      end
      2'b01: begin
        st_wdata_c = {2{store_data_i[15:0]}};
        st_wstrb_c = 4'b0011 << {alu_result_i[1], 1'b0};
      end
      default: ;
    endcase
  end

  // Load lane extraction and sign/zero extension from the latched address
  always_comb begin
    ld_byte_c = mem_rdata_i[7:0];
    case (addr_q[1:0])
      2'b00: ld_byte_c = mem_rdata_i[7:0];
      2'b01: ld_byte_c = mem_rdata_i[15:8];
      2'b10: ld_byte_c = mem_rdata_i[23:16];
      2'b11: ld_byte_c = mem_rdata_i[31:24];
      default: ;
    endcase
    ld_half_c = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      3'b100:  ld_data_c = {24'd0, ld_byte_c};
      3'b001:  ld_data_c = {{16{ld_half_c[15]}}, ld_half_c};
      3'b101:  ld_data_c = {16'd0, ld_half_c};
      default: ld_data_c = mem_rdata_i;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid_i) begin
          if (!mem_op_c || misalign_c) state_d = S_DONE;
          else                         state_d = S_REQ;
        end
      end
      S_REQ:   if (mem_req_ready_i) state_d = S_WAIT;
      S_WAIT:  if (mem_rsp_valid_i) state_d = S_DONE;
      S_DONE:  if (out_ready_i)     state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register
  always_comb begin
    in_ready_o      = 1'b0;
    mem_req_valid_o = 1'b0;
    out_valid_o     = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_o      = 1'b1;
      S_REQ:   mem_req_valid_o = 1'b1;
      S_DONE:  out_valid_o     = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values: latch on accept, capture result on response
  always_comb begin
    addr_d        = addr_q;
    store_d       = store_q;
    funct3_d      = funct3_q;
    rd_d          = rd_q;
    reg_wen_d     = reg_wen_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    out_data_d    = out_data_q;
    out_err_d     = out_err_q;
    out_reg_wen_d = out_reg_wen_q;
    if (state_q == S_IDLE && in_valid_i) begin
      addr_d    = alu_result_i;
      store_d   = mem_wen_i;
      funct3_d  = funct3_i;
      rd_d      = rd_i;
      reg_wen_d = reg_wen_i;
      wdata_d   = mem_wen_i ? st_wdata_c : '0;
      wstrb_d   = mem_wen_i ? st_wstrb_c : '0;
      out_data_d    = alu_result_i;
      out_err_d     = 1'b0;
      out_reg_wen_d = reg_wen_i;
      if (mem_op_c) begin
        // A misaligned access faults with the address; otherwise wait for memory
        out_err_d     = misalign_c;
        out_reg_wen_d = 1'b0;
      end
    end else if (state_q == S_WAIT && mem_rsp_valid_i) begin
      if (mem_rsp_err_i) begin
        out_data_d    = addr_q;
        out_err_d     = 1'b1;
        out_reg_wen_d = 1'b0;
      end else begin
        out_data_d    = store_q ? '0 : ld_data_c;
        out_err_d     = 1'b0;
        out_reg_wen_d = reg_wen_q & ~store_q;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q        <= '0;
      store_q       <= 1'b0;
      funct3_q      <= '0;
      rd_q          <= '0;
      reg_wen_q     <= 1'b0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      out_data_q    <= '0;
      out_err_q     <= 1'b0;
      out_reg_wen_q <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      store_q       <= store_d;
      funct3_q      <= funct3_d;
      rd_q          <= rd_d;
      reg_wen_q     <= reg_wen_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      out_data_q    <= out_data_d;
      out_err_q     <= out_err_d;
      out_reg_wen_q <= out_reg_wen_d;
    end
  end

  assign mem_req_wen_o = store_q;
  assign mem_addr_o    = {addr_q[DATA_LEN-1:2], 2'b00};
  assign mem_wdata_o   = wdata_q;
  assign mem_wstrb_o   = wstrb_q;
  assign out_data_o    = out_data_q;
  assign out_rd_o      = rd_q;
  assign out_reg_wen_o = out_reg_wen_q;
  assign out_err_o     = out_err_q;

endmodule

// File: tb/tb_ysyx_22041211_lsu.sv
// Scoreboard bench for ysyx_22041211_lsu: directed instructions push expected
// requests/results; negedge monitors compare whenever the DUT presents them.
module tb_ysyx_22041211_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid_i, in_ready_o;
  logic [31:0] alu_result_i, store_data_i;
  logic        mem_ren_i, mem_wen_i;
  logic [2:0]  funct3_i;
  logic [4:0]  rd_i;
  logic        reg_wen_i;
  logic        mem_req_valid_o, mem_req_ready_i, mem_req_wen_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic [3:0]  mem_wstrb_o;
  logic        mem_rsp_valid_i;
  logic [31:0] mem_rdata_i;
  logic        mem_rsp_err_i;
  logic        out_valid_o, out_ready_i;
  logic [31:0] out_data_o;
  logic [4:0]  out_rd_o;
  logic        out_reg_wen_o, out_err_o;

  ysyx_22041211_lsu dut (
    .clk(clk), .rst(rst),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i),
    .mem_ren_i(mem_ren_i), .mem_wen_i(mem_wen_i), .funct3_i(funct3_i),
    .rd_i(rd_i), .reg_wen_i(reg_wen_i),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_wen_o(mem_req_wen_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o),
    .mem_rsp_valid_i(mem_rsp_valid_i), .mem_rdata_i(mem_rdata_i),
    .mem_rsp_err_i(mem_rsp_err_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_data_o(out_data_o), .out_rd_o(out_rd_o),
    .out_reg_wen_o(out_reg_wen_o), .out_err_o(out_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        rwen;
    logic        err;
    int          t;
    int          lat;
  } out_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_exp_t;

  out_exp_t out_q[$];
  req_exp_t req_q[$];

  int tests = 0;
  int failed = 0;
  int cyc = 0;

  // Memory/writeback behaviour knobs set by the stimulus
  logic [31:0] rsp_rdata = 32'd0;
  logic        rsp_err = 1'b0;
  logic        rsp_hold = 1'b0;
  logic        stray = 1'b0;
  int          req_stall = 0;
  int          out_stall = 0;
  logic        hs = 1'b0;
  logic        prev_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Request handshake capture for the memory responder
  always @(negedge clk) hs <= mem_req_valid_o && mem_req_ready_i && !rst;

  // Memory and writeback drivers
  initial begin
    mem_req_ready_i = 1'b1;
    out_ready_i     = 1'b1;
    mem_rsp_valid_i = 1'b0;
    mem_rdata_i     = 32'd0;
    mem_rsp_err_i   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      mem_rsp_valid_i = (hs && !rsp_hold) || stray;
      mem_rdata_i     = rsp_rdata;
      mem_rsp_err_i   = rsp_err;
      if (mem_req_valid_o && req_stall > 0) begin
        mem_req_ready_i = 1'b0;
        req_stall--;
      end else begin
        mem_req_ready_i = 1'b1;
      end
      if (out_valid_o && out_stall > 0) begin
        out_ready_i = 1'b0;
        out_stall--;
      end else begin
        out_ready_i = 1'b1;
      end
    end
  end

  // Monitor: compares requests and results against the scoreboard queues
  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (mem_req_valid_o) begin
        chk("req_expected", 32'(req_q.size() != 0), 32'd1);
        chk("req_in_ready", 32'(in_ready_o), 32'd0);
        if (req_q.size() != 0) begin
          chk("req_addr", mem_addr_o, req_q[0].addr);
          chk("req_wen", 32'(mem_req_wen_o), 32'(req_q[0].wen));
          chk("req_wstrb", 32'(mem_wstrb_o), 32'(req_q[0].wstrb));
          if (req_q[0].wen) chk("req_wdata", mem_wdata_o, req_q[0].wdata);
          if (mem_req_ready_i) void'(req_q.pop_front());
        end
      end
      if (out_valid_o) begin
        chk("out_expected", 32'(out_q.size() != 0), 32'd1);
        chk("out_in_ready", 32'(in_ready_o), 32'd0);
        if (out_q.size() != 0) begin
          chk("out_data", out_data_o, out_q[0].data);
          chk("out_rd", 32'(out_rd_o), 32'(out_q[0].rd));
          chk("out_reg_wen", 32'(out_reg_wen_o), 32'(out_q[0].rwen));
          chk("out_err", 32'(out_err_o), 32'(out_q[0].err));
          if (!prev_valid) chk("latency", 32'(cyc - out_q[0].t), 32'(out_q[0].lat));
          if (out_ready_i) void'(out_q.pop_front());
        end
      end
      prev_valid <= out_valid_o;
    end
  end

  // Present one instruction; push expectations in the cycle it is accepted
  task automatic issue(input logic [31:0] alu, input logic [31:0] sd,
                       input logic ren, input logic wen, input logic [2:0] f3,
                       input logic [4:0] rd, input logic rw,
                       input logic [31:0] x_data, input logic x_rw, input logic x_err,
                       input int lat, input logic has_req, input logic [31:0] x_addr,
                       input logic [31:0] x_wdata, input logic [3:0] x_strb);
    logic got;
    out_exp_t oe;
    req_exp_t re;
    got = 1'b0;
    alu_result_i = alu; store_data_i = sd; mem_ren_i = ren; mem_wen_i = wen;
    funct3_i = f3; rd_i = rd; reg_wen_i = rw; in_valid_i = 1'b1;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk);
      if (in_ready_o) begin
        got = 1'b1;
        oe.data = x_data; oe.rd = rd; oe.rwen = x_rw; oe.err = x_err;
        oe.t = cyc; oe.lat = lat;
        out_q.push_back(oe);
        if (has_req) begin
          re.addr = x_addr; re.wen = wen; re.wdata = x_wdata; re.wstrb = x_strb;
          req_q.push_back(re);
        end
      end
      @(posedge clk);
      #1;
    end
    in_valid_i = 1'b0;
    chk("accept", 32'(got), 32'd1);
  endtask

  // Wait (bounded) until every expected result has been observed
  task automatic wait_idle();
    logic done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (out_q.size() == 0 && req_q.size() == 0 && in_ready_o) done = 1'b1;
    end
    chk("drain", 32'(done), 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    in_valid_i = 1'b0; alu_result_i = '0; store_data_i = '0;
    mem_ren_i = 1'b0; mem_wen_i = 1'b0; funct3_i = '0; rd_i = '0; reg_wen_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("rst_out_data", out_data_o, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb_o), 32'd0);
    chk("rst_flags", 32'({out_err_o, out_reg_wen_o, mem_req_wen_o}), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // ADD: pass-through, result one cycle after accept
    issue(32'h12345678, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1,
          32'h12345678, 1'b1, 1'b0, 1, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle();

    // LB / LBU from the top byte
    rsp_rdata = 32'h80FF0000; rsp_err = 1'b0;
    issue(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b000, 5'd6, 1'b1,
          32'hFFFFFF80, 1'b1, 1'b0, 3, 1'b1, 32'h80000000, 32'h0, 4'h0);
    wait_idle();
    issue(32'h80000003, 32'h0, 1'b1, 1'b0, 3'b100, 5'd6, 1'b1,
          32'h00000080, 1'b1, 1'b0, 3, 1'b1, 32'h80000000, 32'h0, 4'h0);
    wait_idle();

    // LH upper half sign-extended, LHU lower half zero-extended, aligned LW
    rsp_rdata = 32'h80011234;
    issue(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b001, 5'd11, 1'b1,
          32'hFFFF8001, 1'b1, 1'b0, 3, 1'b1, 32'h80000000, 32'h0, 4'h0);
    wait_idle();
    rsp_rdata = 32'h1234ABCD;
    issue(32'h80000000, 32'h0, 1'b1, 1'b0, 3'b101, 5'd12, 1'b1,
          32'h0000ABCD, 1'b1, 1'b0, 3, 1'b1, 32'h80000000, 32'h0, 4'h0);
    wait_idle();
    rsp_rdata = 32'hDEADBEEF;
    issue(32'h80000004, 32'h0, 1'b1, 1'b0, 3'b010, 5'd13, 1'b1,
          32'hDEADBEEF, 1'b1, 1'b0, 3, 1'b1, 32'h80000004, 32'h0, 4'h0);
    wait_idle();

    // SH with the memory stalling the request for three cycles
    req_stall = 3;
    issue(32'h80000002, 32'hAAAABEEF, 1'b0, 1'b1, 3'b001, 5'd4, 1'b1,
          32'h0, 1'b0, 1'b0, 6, 1'b1, 32'h80000000, 32'hBEEFBEEF, 4'b1100);
    wait_idle();

    // SB lane 1 and SW
    issue(32'h80000001, 32'h11223344, 1'b0, 1'b1, 3'b000, 5'd0, 1'b0,
          32'h0, 1'b0, 1'b0, 3, 1'b1, 32'h80000000, 32'h44444444, 4'b0010);
    wait_idle();
    issue(32'h80000008, 32'hCAFEBABE, 1'b0, 1'b1, 3'b010, 5'd0, 1'b0,
          32'h0, 1'b0, 1'b0, 3, 1'b1, 32'h80000008, 32'hCAFEBABE, 4'b1111);
    wait_idle();

    // LW bus error, writeback back-pressured for four cycles
    rsp_err = 1'b1; out_stall = 4;
    issue(32'h10000004, 32'h0, 1'b1, 1'b0, 3'b010, 5'd8, 1'b1,
          32'h10000004, 1'b0, 1'b1, 3, 1'b1, 32'h10000004, 32'h0, 4'h0);
    wait_idle();
    rsp_err = 1'b0;

    // Reset while waiting for a response, then a stray response
    rsp_hold = 1'b1;
    issue(32'h20000000, 32'h0, 1'b1, 1'b0, 3'b010, 5'd7, 1'b1,
          32'h0, 1'b1, 1'b0, 3, 1'b1, 32'h20000000, 32'h0, 4'h0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    out_q.delete();
    req_q.delete();
    chk("wait_rst_in_ready", 32'(in_ready_o), 32'd1);
    chk("wait_rst_req_valid", 32'(mem_req_valid_o), 32'd0);
    chk("wait_rst_out_valid", 32'(out_valid_o), 32'd0);
    chk("wait_rst_addr", mem_addr_o, 32'd0);
    chk("wait_rst_out_data", out_data_o, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    rsp_hold = 1'b0;
    stray = 1'b1;
    rsp_rdata = 32'h55555555;
    @(posedge clk);
    #1;
    stray = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stray_out_valid", 32'(out_valid_o), 32'd0);
      chk("stray_in_ready", 32'(in_ready_o), 32'd1);
    end
    @(posedge clk);
    #1;
    issue(32'hA5A5A5A5, 32'h0, 1'b0, 1'b0, 3'b000, 5'd9, 1'b1,
          32'hA5A5A5A5, 1'b1, 1'b0, 1, 1'b0, 32'h0, 32'h0, 4'h0);
    wait_idle();

    // Misaligned LW
`ifdef YSYX_22041211_LSU_MISALIGN_CHECK_EN
    issue(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1,
          32'h80000002, 1'b0, 1'b1, 1, 1'b0, 32'h0, 32'h0, 4'h0);
`else
    rsp_rdata = 32'h13579BDF;
    issue(32'h80000002, 32'h0, 1'b1, 1'b0, 3'b010, 5'd10, 1'b1,
          32'h13579BDF, 1'b1, 1'b0, 3, 1'b1, 32'h80000000, 32'h0, 4'h0);
`endif
    wait_idle();

    repeat (2) @(negedge clk);
    chk("final_out_q_empty", 32'(out_q.size()), 32'd0);
    chk("final_req_q_empty", 32'(req_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/ysyx_22041211_lsu.md
Name:
ysyx_22041211_lsu

Overview:
- Load/store unit directly downstream of the EX-stage ALU: consumes the ALU result as the effective address (or passes it through for non-memory ops), issues one word-aligned request on a valid/ready memory port, and aligns and extends load data. Produces one registered result per instruction for writeback over a valid/ready handshake.

Parameters:
DATA_LEN, 32, data/address width; only 32 supported.

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-high reset
in_valid_i  input  1  EX result valid
in_ready_o  output  1  LSU can accept an instruction
alu_result_i  input  32  ALU result / effective address
store_data_i  input  32  rs2 value for stores
mem_ren_i  input  1  instruction is a load
mem_wen_i  input  1  instruction is a store; never set together with mem_ren_i
funct3_i  input  3  RISC-V funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
rd_i  input  5  destination register
reg_wen_i  input  1  instruction writes rd
mem_req_valid_o  output  1  memory request valid
mem_req_ready_i  input  1  memory accepts request
mem_req_wen_o  output  1  1 = write, 0 = read
mem_addr_o  output  32  {addr[31:2],2'b00}
mem_wdata_o  output  32  lane-replicated store data
mem_wstrb_o  output  4  byte strobes; 0000 on reads
mem_rsp_valid_i  input  1  response valid, single cycle
mem_rdata_i  input  32  read word
mem_rsp_err_i  input  1  bus error, qualified by mem_rsp_valid_i
out_valid_o  output  1  writeback result valid
out_ready_i  input  1  writeback stage accepts
out_data_o  output  32  writeback data
out_rd_o  output  5  destination register
out_reg_wen_o  output  1  register write enable
out_err_o  output  1  access fault or misalignment

Behaviour:
- Reset, asynchronous, effective immediately at any point: state IDLE; in_ready_o=1; mem_req_valid_o=0; out_valid_o=0; all data, strobe and flag outputs 0. An in-flight request is dropped and any later response is ignored.
- States: IDLE, REQ, WAIT, DONE. in_ready_o=1 only in IDLE; at most one instruction in flight.
- IDLE, on in_valid_i&&in_ready_o: latch all inputs. A non-memory op goes to DONE with out_data_o=alu_result_i. A load or store goes to REQ.
- REQ: mem_req_valid_o=1, with address/wen/wdata/wstrb held stable until mem_req_ready_i. Go to WAIT on the handshake cycle.
- WAIT: mem_rsp_valid_i is sampled only here (ignored in every other state); the earliest response is the cycle after acceptance. On response, go to DONE.
- Store lanes: B gives wdata {4{sd[7:0]}}, wstrb 0001<<a[1:0]. H gives {2{sd[15:0]}}, wstrb 0011<<{a[1],0}. W gives sd, wstrb 1111.
- Load extraction: B/BU select byte a[1:0]; H/HU select half a[1]; W takes the whole word. B and H sign-extend; BU and HU zero-extend.
- Stores: out_data_o=0. out_reg_wen_o=reg_wen_i&&!mem_wen_i&&!err.
- On mem_rsp_err_i: out_err_o=1, out_reg_wen_o=0, out_data_o=address.
- DONE: out_valid_o=1, outputs held stable until out_ready_i, then go to IDLE (in_ready_o high next cycle).
- Latency, accepted at T: non-memory op gives out_valid_o at T+1. Memory op with zero-wait memory: req at T+1, rsp at T+2, out_valid_o at T+3.
- Without the optional feature, misaligned accesses truncate: H uses a[1] only; W ignores a[1:0].

Optional Feature:
- Macro: YSYX_22041211_LSU_MISALIGN_CHECK_EN.
- Defined: H with a[0]=1, or W with a[1:0]!=0, issues no memory request and goes IDLE→DONE in one cycle with out_err_o=1, out_reg_wen_o=0, out_data_o=address. This applies to both loads and stores.
- Undefined: no check; truncation as specified in Behaviour.

Test Plan:
- ADD result 0x12345678, rd=5, out_ready_i=1 → out_valid_o at T+1, out_data_o=0x12345678, out_reg_wen_o=1; no mem_req_valid_o.
- LB at 0x80000003, mem_rdata_i=0x80FF0000 → mem_addr_o=0x80000000, wstrb 0000, out_data_o=0xFFFFFF80. LBU at the same address → out_data_o=0x00000080.
- SH at 0x80000002, store_data_i=0xAAAABEEF, mem_req_ready_i low 3 cycles → request held stable, wdata 0xBEEFBEEF, wstrb 1100, out_reg_wen_o=0.
- LW with mem_rsp_err_i=1 at 0x10000004 → out_err_o=1, out_data_o=0x10000004, out_reg_wen_o=0. Then out_ready_i held low 4 cycles → outputs stable and in_ready_o=0 throughout.
- rst asserted during WAIT, then a stray mem_rsp_valid_i arrives → outputs zero immediately, stray response ignored, next instruction accepted normally.
- LW at 0x80000002: with the macro defined → no request, out_err_o=1 at T+1. With it undefined → address 0x80000000, full word returned.
